// File: rtl/mux_n_reg.sv
// N-way registered selector with stall/flush, select echo and sticky out-of-range flag.
// Optional saturating error counter on o_err_cnt when MUXN_ERR_CNT_EN is defined.

module mux_n_reg_lane #(
  parameter int BUS_WIDTH = 32,
  parameter int SEL_WIDTH = 2,
  parameter int LANE      = 0
) (
  input  logic [SEL_WIDTH-1:0] sel,
  input  logic [BUS_WIDTH-1:0] din,
  output logic [BUS_WIDTH-1:0] dout
);
  // One-hot masking; the top ORs all lanes together.
  assign dout = (sel == SEL_WIDTH'(LANE)) ? din : '0;
endmodule

module mux_n_reg #(
  parameter int                   BUS_WIDTH   = 32,
  parameter int                   NUM_INPUTS  = 3,
  parameter int                   SEL_WIDTH   = 2,
  parameter logic [BUS_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [BUS_WIDTH*NUM_INPUTS-1:0] i_datos,
  input  logic [SEL_WIDTH-1:0]            i_sel,
  input  logic                            i_valid,
  input  logic                            i_stall,
  input  logic                            i_flush,
  input  logic                            i_clr_err,
`ifdef MUXN_ERR_CNT_EN
  output logic [7:0]                      o_err_cnt,
`endif
  output logic [BUS_WIDTH-1:0]            o_dato,
  output logic                            o_valid,
  output logic [SEL_WIDTH-1:0]            o_sel_q,
  output logic                            o_sel_err
);

  generate
    if (NUM_INPUTS < 2 || NUM_INPUTS > 16 || (2**SEL_WIDTH) < NUM_INPUTS) begin : g_bad_cfg
      $error("mux_n_reg: illegal NUM_INPUTS/SEL_WIDTH combination");
    end
  endgenerate

  logic [NUM_INPUTS-1:0][BUS_WIDTH-1:0] chan, lane_d;
  logic [BUS_WIDTH-1:0]                 mux_d;
  logic [SEL_WIDTH-1:0]                 eff_sel;
  logic                                 oor, load, err_set;

  assign chan    = i_datos;
  assign oor     = (32'(i_sel) >= NUM_INPUTS);
  // Out-of-range selects fall back to channel 0.
  assign eff_sel = oor ? '0 : i_sel;
  assign load    = !i_flush && !i_stall;
  assign err_set = load && i_valid && oor;

  genvar k;
  generate
    for (k = 0; k < NUM_INPUTS; k++) begin : g_lane
      mux_n_reg_lane #(
        .BUS_WIDTH(BUS_WIDTH),
        .SEL_WIDTH(SEL_WIDTH),
        .LANE     (k)
      ) u_lane (
        .sel (eff_sel),
        .din (chan[k]),
        .dout(lane_d[k])
      );
    end
  endgenerate

  always_comb begin
    mux_d = '0;
    for (int i = 0; i < NUM_INPUTS; i++) mux_d = mux_d | lane_d[i];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_dato  <= RESET_VALUE;
      o_valid <= 1'b0;
      o_sel_q <= '0;
    end else if (i_flush) begin
      o_dato  <= RESET_VALUE;
      o_valid <= 1'b0;
      o_sel_q <= '0;
    end else if (!i_stall) begin
      o_dato  <= mux_d;
      o_valid <= i_valid;
      o_sel_q <= i_sel;
    end
  end

  // Set beats clear; flush leaves the flag alone.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)        o_sel_err <= 1'b0;
    else if (err_set)   o_sel_err <= 1'b1;
    else if (i_clr_err) o_sel_err <= 1'b0;
  end

`ifdef MUXN_ERR_CNT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                          o_err_cnt <= 8'd0;
    else if (err_set && i_clr_err)        o_err_cnt <= 8'd1;
    else if (i_clr_err)                   o_err_cnt <= 8'd0;
    else if (err_set && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench for mux_n_reg: stimulus pushes expected post-edge outputs,
// a negedge monitor pops and compares them on the targeted cycle.

module tb_mux_n_reg;
  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] datos;
  logic [1:0]  sel;
  logic        vld, stall, flush, clr;
  logic [31:0] dato;
  logic        ovld, serr;
  logic [1:0]  selq;

  logic [127:0] datos4;
  logic [1:0]   sel4;
  logic         vld4;
  logic [31:0]  dato4;
  logic         ovld4, serr4;
  logic [1:0]   selq4;

`ifdef MUXN_ERR_CNT_EN
  logic [7:0] ecnt, ecnt4;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        v;
    logic [1:0]  s;
    logic        e;
    string       nm;
  } exp_t;
  exp_t q[$];

  localparam logic [95:0] CH  = {32'h33, 32'h22, 32'h11};
  localparam logic [95:0] CHX = {32'hCC, 32'hBB, 32'hAA};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_n_reg #(.BUS_WIDTH(32), .NUM_INPUTS(3), .SEL_WIDTH(2), .RESET_VALUE(32'h0)) dut (
    .i_clk(clk), .i_reset(rst), .i_datos(datos), .i_sel(sel), .i_valid(vld),
    .i_stall(stall), .i_flush(flush), .i_clr_err(clr),
`ifdef MUXN_ERR_CNT_EN
    .o_err_cnt(ecnt),
`endif
    .o_dato(dato), .o_valid(ovld), .o_sel_q(selq), .o_sel_err(serr)
  );

  mux_n_reg #(.BUS_WIDTH(32), .NUM_INPUTS(4), .SEL_WIDTH(2), .RESET_VALUE(32'h0)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_datos(datos4), .i_sel(sel4), .i_valid(vld4),
    .i_stall(1'b0), .i_flush(1'b0), .i_clr_err(1'b0),
`ifdef MUXN_ERR_CNT_EN
    .o_err_cnt(ecnt4),
`endif
    .o_dato(dato4), .o_valid(ovld4), .o_sel_q(selq4), .o_sel_err(serr4)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".dato"},  dato,         e.d);
      chk({e.nm, ".valid"}, 32'(ovld),    32'(e.v));
      chk({e.nm, ".selq"},  32'(selq),    32'(e.s));
      chk({e.nm, ".err"},   32'(serr),    32'(e.e));
    end
  end

  task automatic step(input string nm, input logic [95:0] d, input logic [1:0] s,
                      input logic v, input logic st, input logic fl, input logic cl,
                      input logic [31:0] ed, input logic ev, input logic [1:0] es, input logic ee);
    exp_t e;
    @(posedge clk); #1;
    datos = d; sel = s; vld = v; stall = st; flush = fl; clr = cl;
    e.cyc = cyc + 1; e.d = ed; e.v = ev; e.s = es; e.e = ee; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expected responses never checked", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; datos = CH; sel = 2'd0; vld = 1'b0; stall = 1'b0; flush = 1'b0; clr = 1'b0;
    datos4 = {32'h44, 32'h33, 32'h22, 32'h11}; sel4 = 2'd3; vld4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.dato", dato, 32'h0);
    chk("rst.valid", 32'(ovld), 32'h0);
    chk("rst.selq", 32'(selq), 32'h0);
    chk("rst.err", 32'(serr), 32'h0);
    rst = 1'b0;

    //    name       data sel v  st fl cl  exp_d   v  s  err
    step("ld2",      CH,  2, 1, 0, 0, 0, 32'h33, 1, 2, 0);
    step("inv3",     CH,  3, 0, 0, 0, 0, 32'h11, 0, 3, 0);
    step("ld1",      CH,  1, 1, 0, 0, 0, 32'h22, 1, 1, 0);
    step("stall_a",  CHX, 0, 1, 1, 0, 0, 32'h22, 1, 1, 0);
    step("stall_b",  CHX, 2, 0, 1, 0, 0, 32'h22, 1, 1, 0);
    step("stall_c",  CHX, 3, 1, 1, 0, 0, 32'h22, 1, 1, 0);
    step("stflush",  CH,  3, 1, 1, 1, 0, 32'h0,  0, 0, 0);
    step("oor3",     CH,  3, 1, 0, 0, 0, 32'h11, 1, 3, 1);
    step("flush_e",  CH,  2, 1, 0, 1, 0, 32'h0,  0, 0, 1);
    step("clr",      CH,  0, 0, 0, 0, 1, 32'h11, 0, 0, 0);
    step("oor3b",    CH,  3, 1, 0, 0, 0, 32'h11, 1, 3, 1);
    step("clr_set",  CH,  3, 1, 0, 0, 1, 32'h11, 1, 3, 1);
    step("clr_ld2",  CH,  2, 1, 0, 0, 1, 32'h33, 1, 2, 0);
    step("ld0",      CH,  0, 1, 0, 0, 0, 32'h11, 1, 0, 0);
    drain();

    // Asynchronous reset between edges while the output stage is valid.
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst.dato", dato, 32'h0);
    chk("arst.valid", 32'(ovld), 32'h0);
    chk("arst.selq", 32'(selq), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst", CH, 1, 1, 0, 0, 0, 32'h22, 1, 1, 0);
    drain();

    chk("n4.dato", dato4, 32'h44);
    chk("n4.selq", 32'(selq4), 32'h3);
    chk("n4.err", 32'(serr4), 32'h0);

`ifdef MUXN_ERR_CNT_EN
    @(posedge clk); #1;
    datos = CH; sel = 2'd3; vld = 1'b1; stall = 1'b0; flush = 1'b0; clr = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("cnt.sat", 32'(ecnt), 32'd255);
    vld = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    chk("cnt.clr", 32'(ecnt), 32'd0);
    vld = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    chk("cnt.clr_inc", 32'(ecnt), 32'd1);
    chk("cnt.n4", 32'(ecnt4), 32'd0);
    clr = 1'b0; vld = 1'b0;
`endif

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
